cordic_arbiter: RTL and testbench
=================================

// Module: cordic_arbiter
// PURPOSE
//  Shares one non-pipelined cordic core between NREQ requesters. Round-robin arbitration;
//  sequences the core's in_valid/ready/out_valid handshake; returns sin/cos tagged with the
//  requester id on a single response port. A watchdog aborts a hung core transaction.
//  Sits between angle producers and the cordic instance (theta 0..65535 = 0..pi/2).
// PARAMETERS
//  NREQ     4    number of requesters (2..16)
//  IDW      2    width of resp_id, = clog2(NREQ)
//  TIMEOUT  64   max cycles in WAIT before abort (>=2)
// PORTS
//  clk            in   1         clock, all logic on rising edge
//  rstb           in   1         synchronous active-low reset
//  req_valid      in   NREQ      per-requester request valid
//  req_ready      out  NREQ      per-requester accept (one-hot or zero)
//  req_theta      in   16*NREQ   requester i angle at [16*i +: 16]
//  resp_valid     out  1         response valid, held until resp_ready
//  resp_ready     in   1         response consumer ready
//  resp_id        out  IDW       index of requester owning the response
//  resp_sin       out  16        captured sin (0 on error)
//  resp_cos       out  16        captured cos (0 on error)
//  resp_err       out  1         1 = watchdog timeout, result invalid
//  cor_theta      out  16        to cordic theta
//  cor_in_valid   out  1         to cordic in_valid
//  cor_ready      in   1         from cordic ready
//  cor_out_valid  in   1         from cordic out_valid
//  cor_sin        in   16        from cordic sin
//  cor_cos        in   16        from cordic cos
// BEHAVIOUR
//  Reset (rstb=0 at edge): state=IDLE, rr pointer=0, watchdog=0; req_ready=0, resp_valid=0,
//   resp_id=0, resp_sin=0, resp_cos=0, resp_err=0, cor_theta=0, cor_in_valid=0. Reset mid-op
//   aborts any transaction; pending result is discarded, no response produced.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: winner = first i with req_valid[i] scanning ptr, ptr+1, ... mod NREQ. req_ready[winner]=1
//   combinationally (only in IDLE, only winner); handshake completes same cycle; latch
//   req_theta[winner] into cor_theta, winner into resp_id; ptr <= (winner+1) mod NREQ; -> ISSUE.
//   No req_valid: stay IDLE, ptr unchanged.
//  ISSUE: cor_in_valid=1 (registered). Cycle with cor_ready=1 = core accept: cor_in_valid<=0,
//   watchdog<=0, -> WAIT. cor_ready=0: hold cor_in_valid and cor_theta stable.
//  WAIT: watchdog increments each cycle. First cycle cor_out_valid=1: capture cor_sin/cor_cos,
//   resp_err<=0, -> RESP. If watchdog reaches TIMEOUT-1 without out_valid: resp_sin=resp_cos=0,
//   resp_err<=1, -> RESP. out_valid and timeout in same cycle: out_valid wins (no error).
//  RESP: resp_valid=1; outputs stable until resp_ready=1; on that cycle resp_valid<=0, -> IDLE.
//   Back-to-back: new grant earliest the cycle after resp handshake.
//  cor_out_valid outside WAIT is ignored. req_ready=0 in all non-IDLE states.
//  Latency: grant at cycle 0, cor_in_valid at 1; core accepts at 1 and asserts out_valid at k
//   -> resp_valid at k+1. Pointer wraps NREQ-1 -> 0. Values pass through unmodified (16-bit).
// TESTING
//  1 single req0 theta=0, core model returns sin=0 cos=65535 after 10 cyc -> resp_id=0,
//    sin=0, cos=65535, err=0, resp_valid exactly 11 cycles after grant.
//  2 all NREQ=4 valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,...; no requester
//    granted twice before others; each resp_id matches its theta (e.g. theta=i*16384).
//  3 cor_ready low 5 cycles in ISSUE -> cor_in_valid held 1, cor_theta stable, then WAIT.
//  4 core never asserts out_valid -> resp_err=1, sin=cos=0 at TIMEOUT cycles after accept;
//    next request then served normally.
//  5 resp_ready held 0 for 8 cycles -> resp_* stable, no req_ready pulse; grant after release.
//  6 rstb=0 for 1 cycle during WAIT -> all outputs reset next cycle, late out_valid ignored,
//    ptr=0 so req0 wins next.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that time-shares one non-pipelined cordic core between NREQ requesters,
// sequencing the core handshake and returning tagged sin/cos with a watchdog abort.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_theta,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [15:0]          resp_sin,
    output logic [15:0]          resp_cos,
    output logic                 resp_err,
    output logic [15:0]          cor_theta,
    output logic                 cor_in_valid,
    input  logic                 cor_ready,
    input  logic                 cor_out_valid,
    input  logic [15:0]          cor_sin,
    input  logic [15:0]          cor_cos
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [15:0]    cor_theta_q, cor_theta_d;
    logic           cor_in_valid_q, cor_in_valid_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [15:0]    resp_sin_q, resp_sin_d;
    logic [15:0]    resp_cos_q, resp_cos_d;
    logic           resp_err_q, resp_err_d;

    logic [IDW-1:0] winner;
    logic           found;
    logic [IDW:0]   scan_idx;

    // Scan ptr, ptr+1, ... (mod NREQ) and take the first asserted request.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(off);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[scan_idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wd_d           = wd_q;
        cor_theta_d    = cor_theta_q;
        cor_in_valid_d = cor_in_valid_q;
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_sin_d     = resp_sin_q;
        resp_cos_d     = resp_cos_q;
        resp_err_d     = resp_err_q;
        req_ready      = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    cor_theta_d       = req_theta[{winner, 4'b0000} +: 16];
                    resp_id_d         = winner;
                    ptr_d             = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
                    cor_in_valid_d    = 1'b1;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cor_ready) begin
                    cor_in_valid_d = 1'b0;
                    wd_d           = '0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the final watchdog cycle still counts as success.
                wd_d = wd_q + WDW'(1);
                if (cor_out_valid) begin
                    resp_sin_d   = cor_sin;
                    resp_cos_d   = cor_cos;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT-1)) begin
                    resp_sin_d   = '0;
                    resp_cos_d   = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            wd_q           <= '0;
            cor_theta_q    <= '0;
            cor_in_valid_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_sin_q     <= '0;
            resp_cos_q     <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            wd_q           <= wd_d;
            cor_theta_q    <= cor_theta_d;
            cor_in_valid_q <= cor_in_valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_sin_q     <= resp_sin_d;
            resp_cos_q     <= resp_cos_d;
            resp_err_q     <= resp_err_d;
        end
    end

    assign cor_theta    = cor_theta_q;
    assign cor_in_valid = cor_in_valid_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_sin     = resp_sin_q;
    assign resp_cos     = resp_cos_q;
    assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed + randomized bench for cordic_arbiter; the bench plays the requesters, the cordic core
// and the response consumer, and predicts grants/latencies/results from a round-robin model.
module tb_cordic_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 16;

    logic                clk = 1'b0;
    logic                rstb;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [16*NREQ-1:0]  req_theta;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [15:0]         resp_sin;
    logic [15:0]         resp_cos;
    logic                resp_err;
    logic [15:0]         cor_theta;
    logic                cor_in_valid;
    logic                cor_ready;
    logic                cor_out_valid;
    logic [15:0]         cor_sin;
    logic [15:0]         cor_cos;

    int                  n_cmp = 0;
    int                  n_err = 0;
    int                  ptr_m = 0;
    logic [15:0]         theta_arr [NREQ];

    cordic_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sin(resp_sin), .resp_cos(resp_cos), .resp_err(resp_err),
        .cor_theta(cor_theta), .cor_in_valid(cor_in_valid), .cor_ready(cor_ready),
        .cor_out_valid(cor_out_valid), .cor_sin(cor_sin), .cor_cos(cor_cos)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_time_limit: observed still running, expected finished");
        $fatal(1, "[TB] simulation time limit hit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid requester scanning from the pointer.
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i = (ptr_m + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_resp_sin"}, resp_sin, 0);
        check({tag, "_resp_cos"}, resp_cos, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_cor_theta"}, cor_theta, 0);
        check({tag, "_cor_in_valid"}, cor_in_valid, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // One full transaction. rdy_wait: ISSUE cycles with cor_ready low; lat: cycles from core
    // accept to out_valid; hang: core never answers; hold: RESP cycles with resp_ready low;
    // abort_at: if >0, reset is pulsed on that WAIT cycle.
    task automatic transact(input logic [NREQ-1:0] valid, input int rdy_wait, input int lat,
                            input bit hang, input int hold, input logic [15:0] sin_v,
                            input logic [15:0] cos_v, input int abort_at);
        int                exp_id;
        logic [NREQ-1:0]   exp_oh;
        logic [15:0]       exp_theta;
        bit                exp_err;
        int                exp_rel;
        int                seen;

        for (int i = 0; i < NREQ; i++) req_theta[16*i +: 16] = theta_arr[i];
        exp_id    = pick(valid);
        exp_oh    = '0;
        exp_oh[exp_id] = 1'b1;
        exp_theta = theta_arr[exp_id];
        exp_err   = hang || (lat > TO);
        exp_rel   = exp_err ? TO + 1 : lat + 1;

        req_valid     = valid;
        cor_ready     = 1'b0;
        cor_out_valid = 1'b0;
        resp_ready    = 1'b0;
        #1;
        check("grant_onehot", req_ready, exp_oh);
        ptr_m = (exp_id + 1) % NREQ;
        step();

        for (int w = 0; w <= rdy_wait; w++) begin
            check("issue_in_valid", cor_in_valid, 1);
            check("issue_theta", cor_theta, exp_theta);
            check("issue_no_ready", req_ready, 0);
            if (w < rdy_wait) begin
                cor_ready     = 1'b0;
                cor_out_valid = 1'b1;
                cor_sin       = 16'($urandom);
                cor_cos       = 16'($urandom);
            end else begin
                cor_ready     = 1'b1;
                cor_out_valid = 1'b0;
            end
            step();
        end
        cor_ready = 1'b0;
        check("accept_in_valid_low", cor_in_valid, 0);

        seen = -1;
        for (int c = 1; c <= TO + 4 && seen < 0; c++) begin
            if (resp_valid) begin
                seen = c;
            end else begin
                check("wait_no_ready", req_ready, 0);
                if (abort_at > 0 && c == abort_at) begin
                    rstb          = 1'b0;
                    req_valid     = '0;
                    cor_out_valid = 1'b0;
                    step();
                    rstb = 1'b1;
                    check_all_zero("abort");
                    for (int k = 0; k < 3; k++) begin
                        cor_out_valid = 1'b1;
                        cor_sin       = sin_v;
                        cor_cos       = cos_v;
                        step();
                        check("abort_late_resp_valid", resp_valid, 0);
                        check("abort_late_in_valid", cor_in_valid, 0);
                    end
                    cor_out_valid = 1'b0;
                    ptr_m = 0;
                    return;
                end
                cor_out_valid = (!hang && c == lat);
                cor_sin       = (!hang && c == lat) ? sin_v : 16'($urandom);
                cor_cos       = (!hang && c == lat) ? cos_v : 16'($urandom);
                step();
            end
        end
        cor_out_valid = 1'b0;
        check("resp_latency", seen, exp_rel);
        check("resp_id", resp_id, exp_id);
        check("resp_err", resp_err, exp_err);
        check("resp_sin", resp_sin, exp_err ? 16'h0 : sin_v);
        check("resp_cos", resp_cos, exp_err ? 16'h0 : cos_v);

        for (int h = 0; h < hold; h++) begin
            check("hold_no_ready", req_ready, 0);
            step();
            check("hold_valid", resp_valid, 1);
            check("hold_sin", resp_sin, exp_err ? 16'h0 : sin_v);
            check("hold_id", resp_id, exp_id);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_released", resp_valid, 0);
    endtask

    initial begin
        rstb = 1'b0; req_valid = '0; req_theta = '0; resp_ready = 1'b0;
        cor_ready = 1'b0; cor_out_valid = 1'b0; cor_sin = '0; cor_cos = '0;
        for (int i = 0; i < NREQ; i++) theta_arr[i] = '0;
        step();
        step();
        check_all_zero("reset");
        rstb = 1'b1;
        step();

        // single request, core answers 10 cycles after grant
        theta_arr[0] = 16'h0000;
        transact(4'b0001, 0, 9, 0, 0, 16'h0000, 16'hFFFF, 0);

        // all requesters busy: strict rotation, theta tagged per requester
        for (int i = 0; i < NREQ; i++) theta_arr[i] = 16'(i * 16384);
        for (int n = 0; n < 8; n++) begin
            transact(4'b1111, 0, $urandom_range(1, 6), 0, 0, 16'($urandom), 16'($urandom), 0);
        end

        // core slow to accept
        transact(4'b0100, 5, 4, 0, 0, 16'h1234, 16'h5678, 0);

        // hung core, then normal service; watchdog boundary on both sides
        transact(4'b0010, 0, 0, 1, 0, 16'hAAAA, 16'h5555, 0);
        transact(4'b1000, 0, 3, 0, 0, 16'h0F0F, 16'hF0F0, 0);
        transact(4'b0001, 1, TO, 0, 0, 16'h7777, 16'h8888, 0);
        transact(4'b0001, 0, TO + 1, 0, 0, 16'h7777, 16'h8888, 0);

        // consumer back-pressure while others keep requesting
        transact(4'b1111, 0, 2, 0, 8, 16'hBEEF, 16'hCAFE, 0);

        // reset during WAIT discards the result and restarts rotation at 0
        transact(4'b0010, 0, 2, 0, 0, 16'h1111, 16'h2222, 0);
        transact(4'b0100, 0, 8, 0, 0, 16'h3333, 16'h4444, 3);
        transact(4'b1111, 0, 2, 0, 0, 16'h5555, 16'h6666, 0);

        // randomized traffic
        for (int n = 0; n < 14; n++) begin
            logic [NREQ-1:0] mask;
            for (int i = 0; i < NREQ; i++) theta_arr[i] = 16'($urandom);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            if (n % 4 == 3) begin
                req_valid = '0;
                #1;
                check("idle_no_ready", req_ready, 0);
                step();
            end
            transact(mask, $urandom_range(0, 3), $urandom_range(1, TO + 2), 0,
                     $urandom_range(0, 2), 16'($urandom), 16'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
